// File: rtl/vram_arbiter.sv
// Shares one VRAM port between the video tile fetcher (fixed priority) and a CPU request/ack FSM.
// Video data appears 2 cycles after its slot; CPU ack arrives 2 cycles after grant; CPU waits for free, eligible cycles.
module vram_arbiter #(
    parameter logic [15:0] VBASE     = 16'h7C00,
    parameter int          V_DISPLAY = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  hpos,
    input  logic [8:0]  vpos,
    input  logic        display_on,
    input  logic        cpu_vblank_only,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  video_data,
    output logic        video_valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_WAIT = 2'd1,
        CPU_ACK  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        video_slot;
    logic        cpu_ok;
    logic        grant;
    logic [15:0] last_addr;
    logic [15:0] video_addr;
    logic        vid_p1;
    logic        vid_p2;
    logic        cpu_is_rd;
    logic [7:0]  cpu_rdata_q;
    logic [7:0]  video_data_q;
    logic        unused_bits;

    // Line/column bit 8 never reaches the 32x32 tile map index.
    assign unused_bits = ^{hpos[8], vpos[8]};

    assign video_slot = !reset && display_on && (hpos[2:0] == 3'd0);
    assign cpu_ok     = !cpu_vblank_only || (int'(vpos) >= V_DISPLAY);
    assign video_addr = VBASE + {6'd0, vpos[7:3], hpos[7:3]};

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && cpu_req && !video_slot && cpu_ok) begin
                    grant     = 1'b1;
                    state_nxt = CPU_WAIT;
                end
            end
            CPU_WAIT: state_nxt = CPU_ACK;
            CPU_ACK:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = last_addr;
        ram_we    = 1'b0;
        ram_wdata = 8'd0;
        if (reset) begin
            ram_addr = 16'd0;
        end else if (video_slot) begin
            ram_addr = video_addr;
        end else if (grant) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_addr    <= 16'd0;
            vid_p1       <= 1'b0;
            vid_p2       <= 1'b0;
            cpu_is_rd    <= 1'b0;
            cpu_rdata_q  <= 8'd0;
            video_data_q <= 8'd0;
        end else begin
            state  <= state_nxt;
            vid_p1 <= video_slot;
            vid_p2 <= vid_p1;
            if (video_slot || grant)
                last_addr <= ram_addr;
            if (vid_p1)
                video_data_q <= ram_rdata;
            if (grant)
                cpu_is_rd <= !cpu_we;
            // Read direction is latched at grant so later input changes cannot corrupt the access.
            if (state == CPU_WAIT && cpu_is_rd)
                cpu_rdata_q <= ram_rdata;
        end
    end

    assign cpu_ack     = !reset && (state == CPU_ACK);
    assign video_valid = !reset && vid_p2;
    assign cpu_rdata   = reset ? 8'd0 : cpu_rdata_q;
    assign video_data  = reset ? 8'd0 : video_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: one cycle per step, inputs driven 1 after posedge, outputs checked 1 later.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        display_on;
    logic        cpu_vblank_only;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  video_data;
    logic        video_valid;

    int tests  = 0;
    int failed = 0;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .cpu_vblank_only(cpu_vblank_only), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .video_data(video_data), .video_valid(video_valid)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; hpos = 9'd0; vpos = 9'd0; display_on = 1'b1; cpu_vblank_only = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hBEEF; cpu_wdata = 8'h99; ram_rdata = 8'hEE;
        cyc(); cyc();
        settle();
        chk("rst_ack", cpu_ack, 0);
        chk("rst_vvalid", video_valid, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_vdata", video_data, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_we", ram_we, 0);

        // CPU read granted in the first cycle after reset release
        reset = 1'b0; display_on = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00;
        settle();
        chk("rd_issue_addr", ram_addr, 16'h1234);
        chk("rd_issue_we", ram_we, 0);
        chk("rd_issue_ack", cpu_ack, 0);
        cyc(); ram_rdata = 8'h3C; settle();
        chk("rd_wait_ack", cpu_ack, 0);
        cyc(); ram_rdata = 8'h00; settle();
        chk("rd_ack", cpu_ack, 1);
        chk("rd_data", cpu_rdata, 8'h3C);
        cpu_req = 1'b0;
        cyc(); settle();
        chk("rd_ack_single", cpu_ack, 0);
        chk("rd_data_hold", cpu_rdata, 8'h3C);

        // Video fetch at vpos=16, hpos=40
        display_on = 1'b1; vpos = 9'd16; hpos = 9'd40; settle();
        chk("vid_addr", ram_addr, 16'h7C45);
        chk("vid_we", ram_we, 0);
        cyc(); hpos = 9'd41; ram_rdata = 8'hA5; settle();
        chk("vid_valid_t1", video_valid, 0);
        cyc(); hpos = 9'd42; ram_rdata = 8'h00; settle();
        chk("vid_valid_t2", video_valid, 1);
        chk("vid_data", video_data, 8'hA5);
        chk("idle_addr_hold", ram_addr, 16'h7C45);
        chk("idle_wdata", ram_wdata, 0);
        cyc(); hpos = 9'd43; settle();
        chk("vid_valid_t3", video_valid, 0);

        // CPU write colliding with a video slot at hpos=8
        vpos = 9'd0; hpos = 9'd8; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h77;
        settle();
        chk("wr_coll_addr", ram_addr, 16'h7C01);
        chk("wr_coll_we", ram_we, 0);
        cyc(); hpos = 9'd9; ram_rdata = 8'h5A; settle();
        chk("wr_issue_addr", ram_addr, 16'h0010);
        chk("wr_issue_we", ram_we, 1);
        chk("wr_issue_wdata", ram_wdata, 8'h77);
        cyc(); hpos = 9'd10; ram_rdata = 8'hFF; settle();
        chk("wr_wait_ack", cpu_ack, 0);
        chk("wr_wait_we", ram_we, 0);
        chk("wr_vid_data", video_data, 8'h5A);
        cyc(); hpos = 9'd11; settle();
        chk("wr_ack", cpu_ack, 1);
        chk("wr_rdata_hold", cpu_rdata, 8'h3C);
        cpu_req = 1'b0;

        // Back-to-back reads with cpu_req held high
        cyc(); display_on = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000; settle();
        chk("b2b_issue1", ram_addr, 16'h2000);
        cyc(); ram_rdata = 8'h11; settle();
        chk("b2b_wait1", cpu_ack, 0);
        cyc(); ram_rdata = 8'h00; cpu_addr = 16'h2001; settle();
        chk("b2b_ack1", cpu_ack, 1);
        chk("b2b_data1", cpu_rdata, 8'h11);
        chk("b2b_no_issue_in_ack", ram_addr, 16'h2000);
        cyc(); settle();
        chk("b2b_issue2", ram_addr, 16'h2001);
        chk("b2b_no_ack_adjacent", cpu_ack, 0);
        cyc(); ram_rdata = 8'h22; settle();
        chk("b2b_wait2", cpu_ack, 0);
        cyc(); ram_rdata = 8'h00; settle();
        chk("b2b_ack2", cpu_ack, 1);
        chk("b2b_data2", cpu_rdata, 8'h22);
        cpu_req = 1'b0;
        cyc(); settle();
        chk("b2b_ack_end", cpu_ack, 0);

        // Vblank-only CPU access held off during active lines
        cpu_vblank_only = 1'b1; vpos = 9'd100; cpu_req = 1'b1; cpu_addr = 16'h3000; settle();
        for (int i = 0; i < 3; i++) begin
            chk("vbl_blocked_addr", ram_addr, 16'h2001);
            cyc(); settle();
        end
        chk("vbl_blocked_ack", cpu_ack, 0);
        vpos = 9'd240; settle();
        chk("vbl_grant", ram_addr, 16'h3000);
        cyc(); vpos = 9'd100; ram_rdata = 8'h44; settle();
        cyc(); ram_rdata = 8'h00; settle();
        chk("vbl_ack", cpu_ack, 1);
        chk("vbl_data", cpu_rdata, 8'h44);
        cpu_req = 1'b0; cpu_vblank_only = 1'b0;

        // Reset in CPU_WAIT abandons the access
        cyc(); cpu_req = 1'b1; cpu_addr = 16'h4000; settle();
        chk("rstw_issue", ram_addr, 16'h4000);
        cyc(); reset = 1'b1; ram_rdata = 8'h55; settle();
        cyc(); settle();
        chk("rstw_ack", cpu_ack, 0);
        chk("rstw_rdata", cpu_rdata, 0);
        chk("rstw_vdata", video_data, 0);
        chk("rstw_addr", ram_addr, 0);
        reset = 1'b0; cpu_req = 1'b0; ram_rdata = 8'h00;
        cyc(); settle();
        chk("rstw_no_late_ack", cpu_ack, 0);
        chk("rstw_idle_addr", ram_addr, 0);
        cpu_req = 1'b1; cpu_addr = 16'h4001; settle();
        chk("rstw_fresh_issue", ram_addr, 16'h4001);
        cyc(); ram_rdata = 8'h66; settle();
        cyc(); ram_rdata = 8'h00; settle();
        chk("rstw_fresh_ack", cpu_ack, 1);
        chk("rstw_fresh_data", cpu_rdata, 8'h66);
        cpu_req = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter VBASE, default 16'h7C00: base address of the 32x32 tile map in VRAM.
REQ-002 Parameter V_DISPLAY, default 240: first non-displayed line; vblank is vpos >= V_DISPLAY.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 hpos  in  9  current pixel column from the sync generator.
REQ-006 vpos  in  9  current line from the sync generator.
REQ-007 display_on  in  1  active-picture flag from the sync generator.
REQ-008 cpu_vblank_only  in  1  when 1, CPU accesses are granted only during vblank.
REQ-009 cpu_req  in  1  CPU request level; cpu_we/cpu_addr/cpu_wdata are held stable until cpu_ack.
REQ-010 cpu_we  in  1  1 = write, 0 = read.
REQ-011 cpu_addr  in  16  CPU VRAM address.
REQ-012 cpu_wdata  in  8  CPU write data.
REQ-013 cpu_ack  out  1  one-cycle completion pulse.
REQ-014 cpu_rdata  out  8  read data, valid when cpu_ack=1 after a read.
REQ-015 ram_addr  out  16  VRAM address; combinational in the issue cycle.
REQ-016 ram_we  out  1  VRAM write strobe; combinational in the issue cycle.
REQ-017 ram_wdata  out  8  VRAM write data.
REQ-018 ram_rdata  in  8  VRAM read data, valid in the cycle after its address was presented.
REQ-019 video_data  out  8  fetched tile code.
REQ-020 video_valid  out  1  one-cycle pulse marking a new video_data.

Function
REQ-021 Video slot: a cycle with display_on=1 and hpos[2:0]=0 is a video slot.
- In a video slot the block SHALL issue a read at ram_addr = VBASE + {vpos[7:3], hpos[7:3]}.
- The offset is 10 bits, zero-extended; the 16-bit add wraps modulo 2^16.
REQ-022 Video priority: a video slot always issues, regardless of CPU state; video is never stalled or dropped.
REQ-023 Video data path:
- Data read for a video fetch issued in cycle T is registered into video_data at the end of T+1.
- video_valid=1 in cycle T+2 only.
REQ-024 CPU FSM states: IDLE, CPU_WAIT, CPU_ACK.
REQ-025 IDLE -> CPU_WAIT when cpu_req=1, the cycle is not a video slot, and (cpu_vblank_only=0 or vpos >= V_DISPLAY).
- The grant cycle is the CPU issue cycle.
- ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
REQ-026 CPU_WAIT -> CPU_ACK unconditionally; on a read, cpu_rdata is loaded from ram_rdata.
REQ-027 CPU_ACK -> IDLE unconditionally; cpu_ack=1 only in CPU_ACK.
- cpu_req is ignored in CPU_ACK, so the next CPU issue is at the earliest the cycle after the ack.
REQ-028 CPU latency: cpu_ack asserts exactly 2 cycles after the issue cycle.
REQ-029 On writes, cpu_rdata SHALL hold its previous value.
REQ-030 Simultaneous request and video slot: video issues; the CPU stays IDLE and is granted in the first later eligible cycle.
REQ-031 In CPU_WAIT and CPU_ACK, video slots still issue normally; the VRAM accepts one address per cycle.
REQ-032 Idle cycles (no issue): ram_we=0, ram_wdata=0, ram_addr holds the last issued address.
REQ-033 ram_we SHALL never be 1 in a video slot or a non-issue cycle.
REQ-034 cpu_vblank_only changing mid-access does not affect an access already issued.

Reset
REQ-035 While reset=1:
- FSM=IDLE.
- cpu_ack=0, video_valid=0, cpu_rdata=0, video_data=0, ram_addr=0.
- No issue occurs: ram_we=0.
REQ-036 Reset mid-access abandons the access; no cpu_ack or video_valid is produced for it after reset deasserts.
REQ-037 The first grant is possible in the first cycle after reset deasserts.

Verification
REQ-038 Video fetch, vpos=16, hpos=40, display_on=1 -> ram_addr=16'h7C45 that cycle; VRAM returns 8'hA5 -> video_data=8'hA5 with video_valid=1 two cycles later.
REQ-039 CPU read, cpu_addr=16'h1234, non-slot cycle, VRAM returns 8'h3C -> ram_addr=16'h1234, ram_we=0 at issue; cpu_ack=1 and cpu_rdata=8'h3C exactly 2 cycles later; single-cycle ack.
REQ-040 CPU write 8'h77 to 16'h0010 asserted on a cycle with hpos=8, display_on=1 -> video issues first; CPU issues at hpos=9 with ram_we=1, ram_wdata=8'h77; cpu_ack at hpos=11.
REQ-041 cpu_vblank_only=1, cpu_req held from vpos=100 -> no CPU issue until vpos=240; then a grant within 1 cycle, and ack 2 cycles after the grant.
REQ-042 Back-to-back: cpu_req held high across two transactions -> issues spaced 3 cycles apart; never two acks in consecutive cycles.
REQ-043 Reset asserted in CPU_WAIT -> no cpu_ack afterwards; all outputs at reset values in the following cycle; a fresh request after deassertion completes normally.
